// File: rtl/instr_fetch_mem_pkg.sv
// Shared constants for the instruction fetch memory: default geometry, NOP encoding
// and the bit positions of the response fault flags.
package instr_fetch_mem_pkg;

  localparam int INST_WIDTH     = 32;
  localparam int INST_ADD_WIDTH = 32;
  localparam int INST_MEM_DEPTH = 256;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int FAULT_W        = 2;
  localparam int FAULT_MISALIGN = 0;
  localparam int FAULT_RANGE    = 1;

endpackage

// File: rtl/instr_rsp_fifo.sv
// Two-entry response FIFO holding packed {addr, fault, instr}; 1-bit pointers wrap
// modulo 2, flush empties it in one edge.
module instr_rsp_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);

  logic [W-1:0] slot_r [2];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   count_r;

  // Slot storage, pointers and occupancy; a simultaneous push and pop keeps the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_r[0] <= '0;
      slot_r[1] <= '0;
      wr_ptr_r  <= 1'b0;
      rd_ptr_r  <= 1'b0;
      count_r   <= 2'd0;
    end else if (flush) begin
      wr_ptr_r  <= 1'b0;
      rd_ptr_r  <= 1'b0;
      count_r   <= 2'd0;
    end else begin
      if (push) begin
        slot_r[wr_ptr_r] <= wdata;
        wr_ptr_r         <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = slot_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/instr_fetch_mem.sv
// Synchronous-read instruction memory with valid/ready fetch channels, one read stage
// (S1) backed by a 2-entry response FIFO, fault decode and a program-load port.
module instr_fetch_mem
  import instr_fetch_mem_pkg::*;
#(
  parameter int DATA_W = INST_WIDTH,
  parameter int ADDR_W = INST_ADD_WIDTH,
  parameter int DEPTH  = INST_MEM_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_instr,
  output logic [ADDR_W-1:0]        rsp_addr,
  output logic [FAULT_W-1:0]       rsp_fault,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic                     flush
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int ENT_W = ADDR_W + FAULT_W + DATA_W;

  logic [DATA_W-1:0]  mem_r [DEPTH];

  logic               s1_valid_r;
  logic [ADDR_W-1:0]  s1_addr_r;
  logic [FAULT_W-1:0] s1_fault_r;
  logic [DATA_W-1:0]  s1_instr_r;

  logic               accept_s;
  logic               pop_s;
  logic               fifo_push_s;
  logic               fifo_pop_s;
  logic               fifo_empty_s;
  logic [1:0]         fifo_count_s;
  logic [1:0]         occ_s;
  logic [FAULT_W-1:0] req_fault_s;
  logic [ENT_W-1:0]   fifo_rdata_s;

  function automatic logic [FAULT_W-1:0] decode_fault(input logic [ADDR_W-1:0] addr);
    logic [FAULT_W-1:0] f;
    f                 = '0;
    f[FAULT_MISALIGN] = (addr[1:0] != 2'b00);
    f[FAULT_RANGE]    = (addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH));
    return f;
  endfunction

  // Program-load write; nonblocking update makes a same-edge read see the old word.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem_r[ld_addr] <= ld_data;
    end
  end

  // S1 read stage: captures accepted request, faulting requests read nothing and carry NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_addr_r  <= '0;
      s1_fault_r <= '0;
      s1_instr_r <= '0;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_addr_r  <= req_addr;
        s1_fault_r <= req_fault_s;
        if (req_fault_s != '0) begin
          s1_instr_r <= DATA_W'(NOP);
        end else begin
          s1_instr_r <= mem_r[req_addr[IDX_W+1:2]];
        end
      end
    end
  end

  // Response head selection and credit: FIFO holds older entries than S1, so it leads.
  always_comb begin
    req_fault_s  = decode_fault(req_addr);
    fifo_empty_s = (fifo_count_s == 2'd0);
    occ_s        = {1'b0, s1_valid_r} + fifo_count_s;
    rsp_valid    = s1_valid_r || !fifo_empty_s;
    if (!fifo_empty_s) begin
      {rsp_addr, rsp_fault, rsp_instr} = fifo_rdata_s;
    end else begin
      {rsp_addr, rsp_fault, rsp_instr} = {s1_addr_r, s1_fault_r, s1_instr_r};
    end
    pop_s       = rsp_valid && rsp_ready;
    fifo_pop_s  = pop_s && !fifo_empty_s;
    fifo_push_s = s1_valid_r && !(fifo_empty_s && rsp_ready);
    req_ready   = !flush && ((occ_s - {1'b0, pop_s}) < 2'd2);
    accept_s    = req_valid && req_ready;
  end

  instr_rsp_fifo #(
    .W (ENT_W)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .flush (flush),
    .wdata ({s1_addr_r, s1_fault_r, s1_instr_r}),
    .rdata (fifo_rdata_s),
    .count (fifo_count_s)
  );

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_instr_fetch_mem;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int DEPTH = 256;
  localparam logic [31:0] WA = 32'hAAAA_0003;
  localparam logic [31:0] WB = 32'hBBBB_0003;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_instr;
  logic [AW-1:0] rsp_addr;
  logic [1:0]    rsp_fault;
  logic          ld_en;
  logic [7:0]    ld_addr;
  logic [DW-1:0] ld_data;
  logic          flush;

  int checks = 0;
  int failures = 0;

  logic [31:0] init_words [4];

  instr_fetch_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_fault (rsp_fault),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic [31:0] instr, input logic [31:0] addr,
                         input logic [1:0] fault);
    chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_instr"}, 64'(rsp_instr), 64'(instr));
    chk({tag, "_addr"},  64'(rsp_addr),  64'(addr));
    chk({tag, "_fault"}, 64'(rsp_fault), 64'(fault));
  endtask

  initial begin
    init_words[0] = 32'h2008_0005;
    init_words[1] = 32'h2009_0007;
    init_words[2] = 32'h1111_1111;
    init_words[3] = WA;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; flush = 1'b0;
    #12 rst_n = 1'b1;
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_instr", 64'(rsp_instr), 64'd0);
    chk("reset_rsp_addr",  64'(rsp_addr),  64'd0);
    chk("reset_rsp_fault", 64'(rsp_fault), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < 4; i++) begin
      ld_en = 1'b1; ld_addr = 8'(i); ld_data = init_words[i];
      tick();
    end
    ld_en = 1'b0;

    // back-to-back fetch, no gap
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
    #1 chk("b2b_ready0", 64'(req_ready), 64'd1);
    tick();
    chk_rsp("b2b_rsp0", 32'h2008_0005, 32'h0, 2'b00);
    req_addr = 32'h4;
    tick();
    chk_rsp("b2b_rsp1", 32'h2009_0007, 32'h4, 2'b00);
    req_valid = 1'b0;
    tick();
    chk("b2b_idle", 64'(rsp_valid), 64'd0);

    // backpressure: two accepted, third stalled, drain in order
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h8;
    tick();
    chk_rsp("bp_first", 32'h1111_1111, 32'h8, 2'b00);
    req_addr = 32'hC;
    #1 chk("bp_ready2", 64'(req_ready), 64'd1);
    tick();
    chk_rsp("bp_hold1", 32'h1111_1111, 32'h8, 2'b00);
    req_addr = 32'h0;
    #1 chk("bp_ready3_blocked", 64'(req_ready), 64'd0);
    tick();
    chk_rsp("bp_hold2", 32'h1111_1111, 32'h8, 2'b00);
    rsp_ready = 1'b1;
    #1 chk("bp_ready_on_pop", 64'(req_ready), 64'd1);
    tick();
    chk_rsp("bp_drain2", WA, 32'hC, 2'b00);
    req_valid = 1'b0;
    tick();
    chk_rsp("bp_drain3", 32'h2008_0005, 32'h0, 2'b00);
    tick();
    chk("bp_empty", 64'(rsp_valid), 64'd0);

    // faults
    req_valid = 1'b1; req_addr = 32'h6;
    tick();
    chk_rsp("flt_misalign", 32'h0, 32'h6, 2'b01);
    req_addr = 32'(DEPTH * 4);
    tick();
    chk_rsp("flt_range", 32'h0, 32'(DEPTH * 4), 2'b10);
    req_addr = 32'(DEPTH * 4 + 1);
    tick();
    chk_rsp("flt_both", 32'h0, 32'(DEPTH * 4 + 1), 2'b11);
    req_valid = 1'b0;
    tick();
    chk("flt_idle", 64'(rsp_valid), 64'd0);

    // load/read collision returns old word, then new word
    req_valid = 1'b1; req_addr = 32'hC; ld_en = 1'b1; ld_addr = 8'd3; ld_data = WB;
    tick();
    chk_rsp("ld_old", WA, 32'hC, 2'b00);
    ld_en = 1'b0;
    tick();
    chk_rsp("ld_new", WB, 32'hC, 2'b00);
    req_valid = 1'b0;
    tick();

    // flush with two buffered responses and a concurrent pop
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
    tick();
    req_addr = 32'h4;
    tick();
    chk_rsp("fl_buffered", 32'h2008_0005, 32'h0, 2'b00);
    flush = 1'b1; req_addr = 32'h8; rsp_ready = 1'b1;
    #1 chk("fl_req_ready", 64'(req_ready), 64'd0);
    tick();
    chk("fl_rsp_valid", 64'(rsp_valid), 64'd0);
    flush = 1'b0;
    #1 chk("fl_ready_after", 64'(req_ready), 64'd1);
    tick();
    chk_rsp("fl_next", 32'h1111_1111, 32'h8, 2'b00);
    req_valid = 1'b0;
    tick();
    chk("fl_idle", 64'(rsp_valid), 64'd0);

    // async reset mid-burst
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
    tick();
    req_addr = 32'h4;
    tick();
    req_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_instr", 64'(rsp_instr), 64'd0);
    chk("rst_rsp_addr",  64'(rsp_addr),  64'd0);
    chk("rst_rsp_fault", 64'(rsp_fault), 64'd0);
    tick();
    #2 rst_n = 1'b1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_idle", 64'(rsp_valid), 64'd0);
    req_valid = 1'b1; req_addr = 32'h4; rsp_ready = 1'b1;
    tick();
    chk_rsp("rst_first", 32'h2009_0007, 32'h4, 2'b00);
    req_valid = 1'b0;
    tick();
    chk("rst_drained", 64'(rsp_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
